// File: rtl/div_if.sv
// Issue/writeback handshake bundle for the iterative divide unit.
// The issue stage holds the master side; div_unit holds the slave side.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       div_op;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rd_val_out;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, div_op, flush, out_ready,
    input  in_ready, out_valid, rd_val_out, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, div_op, flush, out_ready,
    output in_ready, out_valid, rd_val_out, busy
  );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring shift-subtract, one quotient bit per cycle, with early exit
// for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | shift-subtract iterations in progress
// DONE  | result registered, out_valid high until out_ready
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  div_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rd_val_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             accept;
  logic             op_signed;
  logic             op_rem;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic             ovf;
  logic             special;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] special_val;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] calc_val;
  logic             last_iter;

  // Request decode: operand magnitudes and special-case detection.
  assign accept    = (state_q == IDLE) && bus.in_valid && !bus.flush;
  assign op_signed = ~bus.div_op[0];
  assign op_rem    = bus.div_op[1];
  assign a_neg     = op_signed & bus.in_a[WIDTH-1];
  assign b_neg     = op_signed & bus.in_b[WIDTH-1];
  assign a_mag     = a_neg ? (-bus.in_a) : bus.in_a;
  assign b_mag     = b_neg ? (-bus.in_b) : bus.in_b;
  assign b_zero    = (bus.in_b == '0);
  assign ovf       = op_signed && (bus.in_a == MIN_NEG) && (bus.in_b == '1);
  assign special   = b_zero | ovf;

  // Preloaded result for the early-exit cases; no sign fixup applies here.
  always_comb begin
    special_val = '0;
    if (b_zero) begin
      special_val = op_rem ? bus.in_a : '1;
    end else if (ovf) begin
      special_val = op_rem ? '0 : MIN_NEG;
    end
  end

  // One restoring step; the borrow out of the widened subtraction decides
  // whether the trial remainder is kept.
  assign shifted   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial     = {1'b0, shifted} - {2'b00, dvs_q};
  assign borrow    = trial[WIDTH+1];
  assign rem_step  = borrow ? shifted : trial[WIDTH:0];
  assign quo_step  = {quo_q[WIDTH-2:0], ~borrow};
  assign quo_fix   = neg_quo_q ? (-quo_step) : quo_step;
  assign rem_fix   = neg_rem_q ? (-rem_step[WIDTH-1:0]) : rem_step[WIDTH-1:0];
  assign calc_val  = op_q[1] ? rem_fix : quo_fix;
  assign last_iter = (state_q == CALC) && (cnt_q == '0);

  // Next-state decode; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch on accept and per-cycle shift-subtract in CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      rem_q     <= '0;
      quo_q     <= a_mag;
      dvs_q     <= b_mag;
      cnt_q     <= CW'(WIDTH - 1);
      op_q      <= bus.div_op;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
    end else if (state_q == CALC) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Result register, loaded only on entry to DONE so it holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_val_q <= '0;
    end else if (accept && special) begin
      rd_val_q <= special_val;
    end else if (last_iter && !bus.flush) begin
      rd_val_q <= calc_val;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.rd_val_out = rd_val_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a queue-based scoreboard: the driver
// pushes expected result and latency, the monitor pops on out_valid.
module tb_div_unit;
  localparam int WIDTH = 32;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_if #(.WIDTH(WIDTH)) bus ();

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_val_q [$];
  int          exp_lat_q [$];
  string       exp_name_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: latency counts edges from the accept edge (inclusive) until
  // out_valid is first seen; each result is compared against the queue head.
  initial begin : monitor
    int  lat;
    bit  active;
    bit  seen;
    logic [31:0] ev;
    int  el;
    string en;
    lat = 0;
    active = 1'b0;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
        seen = 1'b0;
      end else begin
        if (active) lat++;
        if (bus.out_valid && !seen) begin
          seen = 1'b1;
          if (exp_val_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got out_valid=1 rd_val=%h expected no result", bus.rd_val_out);
          end else begin
            ev = exp_val_q.pop_front();
            el = exp_lat_q.pop_front();
            en = exp_name_q.pop_front();
            check({en, "_value"}, bus.rd_val_out, ev);
            check({en, "_latency"}, 32'(lat), 32'(el));
          end
        end
        if (!bus.out_valid) seen = 1'b0;
        if (bus.in_valid && bus.in_ready && !bus.flush) begin
          active = 1'b1;
          lat = 0;
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int hold);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.div_op   = op;
    bus.in_a     = a;
    bus.in_b     = b;
    exp_val_q.push_back(exp);
    exp_lat_q.push_back(lat);
    exp_name_q.push_back(name);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n = 0;
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      check({name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({name, "_hold_value"}, bus.rd_val_out, exp);
      check({name, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check({name, "_retire_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_retire_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.div_op    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rd_val", bus.rd_val_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op("div_min_0", OP_DIV, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op("divu_min_ones", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0);
    run_op("bp_divu_1000_10", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, 10);

    // flush in the middle of CALC discards the operation
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.div_op   = OP_DIVU;
    bus.in_a     = 32'h1234_5678;
    bus.in_b     = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("flush_pre_busy", 32'(bus.busy), 32'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);

    // flush together with in_valid in IDLE must not accept
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 32'(bus.busy), 32'd0);
    repeat (40) @(negedge clk);
    check("flush_quiet_out_valid", 32'(bus.out_valid), 32'd0);

    run_op("divu_ones_3", OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 33, 0);

    // asynchronous reset between clock edges in CALC
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.div_op   = OP_DIV;
    bus.in_a     = 32'd1000;
    bus.in_b     = 32'hFFFF_FFF9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("arst_pre_busy", 32'(bus.busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_rd_val", bus.rd_val_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("div_1000_m7", OP_DIV, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 33, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_val_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
